// File: rtl/fifo_frame_serializer.sv
// Drains 32-bit words from a FIFO and emits them as a byte stream, closing
// every FRAME_WORDS words with a two's-complement checksum byte flagged by byte_last.
module fifo_frame_serializer #(
  parameter int FRAME_WORDS = 4,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_data,
  output logic        fifo_read,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        byte_last,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {FETCH, SHIFT, CSUM} state_t;

  localparam logic [7:0] FRAME_LEN = 8'(FRAME_WORDS);

  state_t      state_reg;
  logic [31:0] hold_reg;
  logic [1:0]  index_reg;
  logic [7:0]  word_count_reg;
  logic [7:0]  acc_reg;
  logic [7:0]  acc_next;
  logic        handshake;
  logic [7:0]  fifo_lane [4];
  logic [7:0]  hold_lane [4];

  // Lane k is the k-th byte to be transmitted, so byte order is fixed here once.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam int POS = MSB_FIRST ? 3 - gi : gi;
      assign fifo_lane[gi] = fifo_data[8*POS +: 8];
      assign hold_lane[gi] = hold_reg[8*POS +: 8];
    end
  endgenerate

  assign fifo_read = (state_reg == FETCH) && !fifo_empty;
  assign handshake = byte_valid && byte_ready;
  assign acc_next  = acc_reg + byte_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= FETCH;
      hold_reg       <= 32'h0;
      index_reg      <= 2'd0;
      word_count_reg <= 8'd0;
      acc_reg        <= 8'd0;
      byte_data      <= 8'd0;
      byte_valid     <= 1'b0;
      byte_last      <= 1'b0;
      frame_count    <= 16'd0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (fifo_read) begin
            hold_reg       <= fifo_data;
            index_reg      <= 2'd0;
            word_count_reg <= word_count_reg + 8'd1;
            byte_data      <= fifo_lane[0];
            byte_valid     <= 1'b1;
            state_reg      <= SHIFT;
          end
        end
        SHIFT: begin
          if (handshake) begin
            acc_reg   <= acc_next;
            index_reg <= index_reg + 2'd1;
            if (index_reg == 2'd3) begin
              if (word_count_reg == FRAME_LEN) begin
                byte_data <= 8'd0 - acc_next;
                byte_last <= 1'b1;
                state_reg <= CSUM;
              end else begin
                byte_data  <= 8'd0;
                byte_valid <= 1'b0;
                state_reg  <= FETCH;
              end
            end else begin
              byte_data <= hold_lane[index_reg + 2'd1];
            end
          end
        end
        CSUM: begin
          if (handshake) begin
            acc_reg        <= 8'd0;
            word_count_reg <= 8'd0;
            frame_count    <= frame_count + 16'd1;
            byte_data      <= 8'd0;
            byte_valid     <= 1'b0;
            byte_last      <= 1'b0;
            state_reg      <= FETCH;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_serializer.sv
// Directed bench: two serializer instances (2-word MSB-first, 1-word LSB-first)
// fed from queue-modelled FIFOs, with byte logs compared against hand-built vectors.
module tb_fifo_frame_serializer;

  logic        clock;
  logic        reset;

  logic        fifo_empty_a, fifo_read_a, byte_valid_a, byte_ready_a, byte_last_a;
  logic [31:0] fifo_data_a;
  logic [7:0]  byte_data_a;
  logic [15:0] frame_count_a;

  logic        fifo_empty_b, fifo_read_b, byte_valid_b, byte_ready_b, byte_last_b;
  logic [31:0] fifo_data_b;
  logic [7:0]  byte_data_b;
  logic [15:0] frame_count_b;

  fifo_frame_serializer #(.FRAME_WORDS(2), .MSB_FIRST(1'b1)) dut_a (
    .clock(clock), .reset(reset),
    .fifo_empty(fifo_empty_a), .fifo_data(fifo_data_a), .fifo_read(fifo_read_a),
    .byte_data(byte_data_a), .byte_valid(byte_valid_a), .byte_ready(byte_ready_a),
    .byte_last(byte_last_a), .frame_count(frame_count_a)
  );

  fifo_frame_serializer #(.FRAME_WORDS(1), .MSB_FIRST(1'b0)) dut_b (
    .clock(clock), .reset(reset),
    .fifo_empty(fifo_empty_b), .fifo_data(fifo_data_b), .fifo_read(fifo_read_b),
    .byte_data(byte_data_b), .byte_valid(byte_valid_b), .byte_ready(byte_ready_b),
    .byte_last(byte_last_b), .frame_count(frame_count_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] qa[$], qb[$];
  logic [8:0]  log_a[$], log_b[$];
  int          pops_a, pops_b;
  int          n_checks, n_pass;
  int          stall_errs, gap_errs;
  bit          gap_watch, bp_random, stall_pending;
  logic [8:0]  stall_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_log(input string tag, input logic [8:0] got[$], input logic [8:0] exp[$]);
    check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp[i]));
      else check($sformatf("%s_b%0d", tag, i), 32'h1ff_ffff, 32'(exp[i]));
    end
  endtask

  task automatic sync_fifo();
    fifo_empty_a = (qa.size() == 0);
    fifo_data_a  = 32'h0;
    if (qa.size() != 0) fifo_data_a = qa[0];
    fifo_empty_b = (qb.size() == 0);
    fifo_data_b  = 32'h0;
    if (qb.size() != 0) fifo_data_b = qb[0];
  endtask

  // One clock: sample on the falling edge, apply pops/handshakes after the rising edge.
  task automatic cycle();
    logic ra, rb, ha, hb, rs;
    logic [8:0] ba, bb;
    @(negedge clock);
    rs = reset;
    ra = fifo_read_a;
    rb = fifo_read_b;
    ha = byte_valid_a && byte_ready_a;
    hb = byte_valid_b && byte_ready_b;
    ba = {byte_last_a, byte_data_a};
    bb = {byte_last_b, byte_data_b};
    if (gap_watch && (byte_valid_a || fifo_read_a)) gap_errs++;
    if (stall_pending && (!byte_valid_a || ba != stall_val)) stall_errs++;
    stall_pending = byte_valid_a && !byte_ready_a && !rs;
    stall_val     = ba;
    @(posedge clock);
    #1;
    if (ra && qa.size() != 0) begin qa.delete(0); pops_a++; end
    if (rb && qb.size() != 0) begin qb.delete(0); pops_b++; end
    if (ha && !rs) log_a.push_back(ba);
    if (hb && !rs) log_b.push_back(bb);
    sync_fifo();
    if (bp_random) byte_ready_a = 1'($urandom_range(0, 1));
  endtask

  logic [8:0]  exp_q[$];
  logic [31:0] w;
  logic [7:0]  s, b;
  int          guard, errs;

  initial begin
    n_checks = 0; n_pass = 0; pops_a = 0; pops_b = 0;
    stall_errs = 0; gap_errs = 0; gap_watch = 0; bp_random = 0; stall_pending = 0;
    reset = 1'b1;
    byte_ready_a = 1'b1;
    byte_ready_b = 1'b1;
    sync_fifo();

    // Reset / idle
    repeat (3) cycle();
    check("rst_valid_a", 32'(byte_valid_a), 32'd0);
    check("rst_last_a",  32'(byte_last_a),  32'd0);
    check("rst_data_a",  32'(byte_data_a),  32'd0);
    check("rst_frames_a", 32'(frame_count_a), 32'd0);
    check("rst_read_a",  32'(fifo_read_a),  32'd0);
    check("rst_valid_b", 32'(byte_valid_b), 32'd0);
    check("rst_pops",    32'(pops_a + pops_b), 32'd0);
    reset = 1'b0;
    cycle();

    // Basic frame: 01..08 sum to 0x24, checksum 0xDC
    qa.push_back(32'h01020304);
    qa.push_back(32'h05060708);
    sync_fifo();
    repeat (15) cycle();
    exp_q = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006, 9'h007, 9'h008, 9'h1DC};
    check_log("basic", log_a, exp_q);
    check("basic_pops",   32'(pops_a), 32'd2);
    check("basic_frames", 32'(frame_count_a), 32'd1);
    check("basic_idle",   32'(byte_valid_a), 32'd0);

    // LSB-first, one word per frame: D4+C3+B2+A1 = 0x2EA, checksum 0x16
    qb.push_back(32'hA1B2C3D4);
    sync_fifo();
    repeat (8) cycle();
    exp_q = '{9'h0D4, 9'h0C3, 9'h0B2, 9'h0A1, 9'h116};
    check_log("order", log_b, exp_q);
    check("order_pops",   32'(pops_b), 32'd1);
    check("order_frames", 32'(frame_count_b), 32'd1);

    // Back-pressure: 10 frames with random byte_ready
    log_a.delete();
    pops_a = 0;
    exp_q.delete();
    for (int f = 0; f < 10; f++) begin
      s = 8'd0;
      for (int k = 0; k < 2; k++) begin
        int i;
        i = f * 2 + k;
        w = {8'(i), 8'(i * 7 + 1), 8'(8'hA5 ^ 8'(i)), 8'(255 - i * 3)};
        qa.push_back(w);
        for (int j = 0; j < 4; j++) begin
          b = w[31 - 8*j -: 8];
          exp_q.push_back({1'b0, b});
          s = s + b;
        end
      end
      exp_q.push_back({1'b1, 8'd0 - s});
    end
    sync_fifo();
    bp_random = 1;
    guard = 0;
    while (log_a.size() < 90 && guard < 3000) begin
      cycle();
      guard++;
    end
    bp_random = 0;
    byte_ready_a = 1'b1;
    check("bp_timeout", 32'(guard < 3000), 32'd1);
    errs = 0;
    for (int i = 0; i < 90; i++)
      if (i >= log_a.size() || log_a[i] !== exp_q[i]) errs++;
    check("bp_seq_errs", 32'(errs), 32'd0);
    check("bp_len",      32'(log_a.size()), 32'd90);
    check("bp_pops",     32'(pops_a), 32'd20);
    check("bp_stall_errs", 32'(stall_errs), 32'd0);
    check("bp_frames",   32'(frame_count_a), 32'd11);

    // Underrun mid-frame: 11+22+33+44+55+66+77+88 = 0x264, checksum 0x9C
    repeat (3) cycle();
    log_a.delete();
    pops_a = 0;
    qa.push_back(32'h11223344);
    sync_fifo();
    repeat (10) cycle();
    gap_watch = 1;
    repeat (20) cycle();
    gap_watch = 0;
    check("gap_errs", 32'(gap_errs), 32'd0);
    check("gap_pops", 32'(pops_a), 32'd1);
    qa.push_back(32'h55667788);
    sync_fifo();
    repeat (10) cycle();
    exp_q = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066, 9'h077, 9'h088, 9'h19C};
    check_log("underrun", log_a, exp_q);
    check("underrun_frames", 32'(frame_count_a), 32'd12);

    // Reset after byte 1 of the second word of a frame
    log_a.delete();
    qa.push_back(32'h01010101);
    qa.push_back(32'h02020202);
    sync_fifo();
    guard = 0;
    while (log_a.size() < 6 && guard < 50) begin
      cycle();
      guard++;
    end
    check("mid_reach", 32'(log_a.size()), 32'd6);
    reset = 1'b1;
    byte_ready_a = 1'b0;
    cycle();
    check("mid_valid",  32'(byte_valid_a), 32'd0);
    check("mid_data",   32'(byte_data_a),  32'd0);
    check("mid_last",   32'(byte_last_a),  32'd0);
    check("mid_frames", 32'(frame_count_a), 32'd0);
    reset = 1'b0;
    byte_ready_a = 1'b1;
    log_a.delete();
    // Post-reset frame: 10+20+30+40+01+02+03+04 = 0xAA, checksum 0x56
    qa.push_back(32'h10203040);
    qa.push_back(32'h01020304);
    sync_fifo();
    repeat (15) cycle();
    exp_q = '{9'h010, 9'h020, 9'h030, 9'h040, 9'h001, 9'h002, 9'h003, 9'h004, 9'h156};
    check_log("post_rst", log_a, exp_q);
    check("post_rst_frames", 32'(frame_count_a), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
